// File: rtl/pipelined_tree_multiplier_if.sv
// Operand/result handshake bundle for the pipelined tree multiplier.
// master = operand issuer and result consumer; slave = the multiplier.
interface pipelined_tree_multiplier_if #(
  parameter int unsigned WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/pipelined_tree_multiplier.sv
// Pipelined carry-save tree multiplier with per-operation signed/unsigned mode.
// Operands are registered, reduced by 3:2 levels spread across the pipeline, then summed.
module pipelined_tree_multiplier #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  pipelined_tree_multiplier_if.slave        bus
);
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned Rows = WIDTH + 2;
  localparam int unsigned NReg = (STAGES > 1) ? STAGES - 1 : 1;

  function automatic int unsigned reduce_rows(input int unsigned n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int unsigned rows_at(input int unsigned level);
    int unsigned n;
    n = Rows;
    for (int unsigned i = 0; i < level; i++) n = reduce_rows(n);
    return n;
  endfunction

  function automatic int unsigned count_levels();
    int unsigned n;
    int unsigned l;
    n = Rows;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 2) begin
        n = reduce_rows(n);
        l++;
      end
    end
    return l;
  endfunction

  localparam int unsigned Levels = count_levels();

  // Reduction level whose rows pipeline register k (1..STAGES-1) captures.
  function automatic int unsigned cut_level(input int unsigned k);
    int unsigned d;
    d = (STAGES > 1) ? STAGES - 1 : 1;
    return (Levels * k + d - 1) / d;
  endfunction

  function automatic int unsigned reg_at(input int unsigned level);
    int unsigned k;
    k = 0;
    for (int unsigned j = 1; j < STAGES; j++) begin
      if (cut_level(j) == level) k = j;
    end
    return k;
  endfunction

  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              mode_q;
  logic [STAGES-1:0] valid_q;
  logic [PW-1:0]     rows_q   [NReg][Rows];
  logic [PW-1:0]     cut_rows [NReg][Rows];
  logic [PW-1:0]     pp       [Rows];
  logic [PW-1:0]     product;
  logic              advance;

  assign advance = en && (!valid_q[STAGES-1] || bus.out_ready);

  assign bus.in_ready    = advance;
  assign bus.out_valid   = valid_q[STAGES-1];
  assign bus.out_product = product;

  // Rows 0..WIDTH-1 add b[i]*a; the extended sign bit of b weighs -2^WIDTH, so its
  // row is subtracted as ~x plus a +1 correction row.
  always_comb begin
    logic [PW-1:0] a_ext;
    logic          b_sign;
    a_ext  = {{WIDTH{mode_q & a_q[WIDTH-1]}}, a_q};
    b_sign = mode_q & b_q[WIDTH-1];
    for (int i = 0; i < WIDTH; i++) pp[i] = b_q[i] ? (a_ext << i) : '0;
    pp[WIDTH]     = b_sign ? ~(a_ext << WIDTH) : '0;
    pp[WIDTH + 1] = {{(PW - 1){1'b0}}, b_sign};
  end

  always_comb begin
    logic [PW-1:0] cur [Rows];
    logic [PW-1:0] nxt [Rows];
    int unsigned   grp;
    int unsigned   k;
    for (int r = 0; r < Rows; r++) begin
      cur[r] = pp[r];
      nxt[r] = '0;
    end
    for (int n = 0; n < NReg; n++) begin
      for (int r = 0; r < Rows; r++) cut_rows[n][r] = '0;
    end
    for (int unsigned l = 1; l <= Levels; l++) begin
      grp = rows_at(l - 1) / 3;
      for (int r = 0; r < Rows; r++) nxt[r] = '0;
      for (int unsigned j = 0; j < grp; j++) begin
        nxt[2*j]   = cur[3*j] ^ cur[3*j+1] ^ cur[3*j+2];
        nxt[2*j+1] = ((cur[3*j] & cur[3*j+1]) | (cur[3*j] & cur[3*j+2]) |
                      (cur[3*j+1] & cur[3*j+2])) << 1;
      end
      for (int unsigned i = 3 * grp; i < Rows; i++) nxt[i - grp] = cur[i];
      k = reg_at(l);
      for (int r = 0; r < Rows; r++) begin
        if (k != 0) cut_rows[k - 1][r] = nxt[r];
        cur[r] = (k != 0) ? rows_q[k - 1][r] : nxt[r];
      end
    end
    // Only rows 0 and 1 survive the tree; the rest are constant zero.
    product = '0;
    for (int r = 0; r < Rows; r++) product = product + cur[r];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      valid_q <= '0;
      for (int n = 0; n < NReg; n++) begin
        for (int r = 0; r < Rows; r++) rows_q[n][r] <= '0;
      end
    end else if (advance) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      mode_q  <= bus.signed_mode;
      valid_q <= STAGES'({valid_q, bus.in_valid});
      for (int n = 0; n < NReg; n++) begin
        for (int r = 0; r < Rows; r++) rows_q[n][r] <= cut_rows[n][r];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Directed bench: a 32-bit/3-stage and an 8-bit/1-stage multiplier share one stimulus
// port; sel picks which instance is driven and observed.
module tb_pipelined_tree_multiplier;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, sel, in_valid, mode, out_ready;
  logic [31:0] op_x, op_y;
  int          total = 0;
  int          bad   = 0;

  logic [31:0] tab_a [8];
  logic [31:0] tab_b [8];
  logic        tab_m [8];
  logic [63:0] tab_e [8];

  pipelined_tree_multiplier_if #(.WIDTH(32)) ia ();
  pipelined_tree_multiplier_if #(.WIDTH(8))  ib ();

  pipelined_tree_multiplier #(.WIDTH(32), .STAGES(3)) dut_w32 (
    .clk(clk), .reset(reset), .en(en), .bus(ia)
  );
  pipelined_tree_multiplier #(.WIDTH(8), .STAGES(1)) dut_w8 (
    .clk(clk), .reset(reset), .en(en), .bus(ib)
  );

  assign ia.in_valid    = in_valid & ~sel;
  assign ia.a           = op_x;
  assign ia.b           = op_y;
  assign ia.signed_mode = mode;
  assign ia.out_ready   = out_ready;
  assign ib.in_valid    = in_valid & sel;
  assign ib.a           = op_x[7:0];
  assign ib.b           = op_y[7:0];
  assign ib.signed_mode = mode;
  assign ib.out_ready   = out_ready;

  logic        obs_valid, obs_ready;
  logic [63:0] obs_prod;
  assign obs_valid = sel ? ib.out_valid : ia.out_valid;
  assign obs_ready = sel ? ib.in_ready : ia.in_ready;
  assign obs_prod  = sel ? {48'd0, ib.out_product} : ia.out_product;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input logic [31:0] x, input logic [31:0] y,
                     input logic m, input logic [63:0] e);
    tab_a[i] = x;
    tab_b[i] = y;
    tab_m[i] = m;
    tab_e[i] = e;
  endtask

  task automatic drive(input int i);
    in_valid = 1'b1;
    op_x     = tab_a[i];
    op_y     = tab_b[i];
    mode     = tab_m[i];
  endtask

  // Back-to-back issue with no stalls; each result must appear exactly lat cycles later.
  task automatic stream(input int n, input int lat, input string tag);
    for (int i = 0; i < n + lat; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (i < n) drive(i);
      #1;
      if (i == 0) chk1({tag, "_in_ready"}, obs_ready, 1'b1);
      if (i >= lat) begin
        chk1({tag, "_valid"}, obs_valid, 1'b1);
        chk({tag, "_prod"}, obs_prod, tab_e[i - lat]);
      end else begin
        chk1({tag, "_early"}, obs_valid, 1'b0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk1({tag, "_drain"}, obs_valid, 1'b0);
  endtask

  // Issue n ops while the consumer stalls for 4 cycles right after the first result.
  task automatic backpressure(input int n, input int lat, input string tag);
    int oi;
    int ri;
    oi = 0;
    ri = 0;
    for (int cyc = 0; cyc < 60 && ri < n; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= lat + 1 && cyc < lat + 5);
      in_valid  = 1'b0;
      if (oi < n) drive(oi);
      #1;
      if (!out_ready) begin
        chk1({tag, "_stall_valid"}, obs_valid, 1'b1);
        chk({tag, "_stall_prod"}, obs_prod, tab_e[ri]);
        chk1({tag, "_stall_in_ready"}, obs_ready, 1'b0);
      end else if (obs_valid) begin
        chk({tag, "_out"}, obs_prod, tab_e[ri]);
        ri++;
      end
      if (in_valid && obs_ready) oi++;
    end
    chk({tag, "_count"}, 64'(ri), 64'(n));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk1({tag, "_no_dup"}, obs_valid, 1'b0);
    end
  endtask

  initial begin
    reset     = 1'b0;
    en        = 1'b1;
    sel       = 1'b0;
    in_valid  = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b1;
    op_x      = '0;
    op_y      = '0;
    #3;
    chk1("rst_valid_w32", ia.out_valid, 1'b0);
    chk("rst_prod_w32", ia.out_product, 64'd0);
    chk1("rst_ready_w32", ia.in_ready, 1'b1);
    chk1("rst_valid_w8", ib.out_valid, 1'b0);
    chk("rst_prod_w8", {48'd0, ib.out_product}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    put(0, 32'd35, 32'd96, 1'b1, 64'd3360);
    put(1, 32'hFFFF_FFF1, 32'd20, 1'b1, 64'hFFFF_FFFF_FFFF_FED4);
    stream(2, 3, "basic_w32");

    put(0, 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE);
    put(1, 32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    put(2, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    put(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    put(4, 32'd3672, 32'd9648, 1'b0, 64'd35427456);
    stream(5, 3, "modes_w32");

    put(0, 32'd1, 32'd40, 1'b0, 64'd40);
    put(1, 32'd36, 32'd42, 1'b0, 64'd1512);
    put(2, 32'd165, 32'd348, 1'b0, 64'd57420);
    put(3, 32'd0, 32'd64, 1'b1, 64'd0);
    put(4, 32'hFFFF_FFEF, 32'hFFFF_FFEF, 1'b1, 64'd289);
    put(5, 32'd7, 32'd7, 1'b1, 64'd49);
    backpressure(6, 3, "bp_w32");

    // Enable freeze with the first op at the output and the second behind it.
    put(0, 32'd2, 32'd5, 1'b0, 64'd10);
    put(1, 32'd11, 32'd13, 1'b0, 64'd143);
    @(negedge clk); drive(0);
    @(negedge clk); drive(1);
    @(negedge clk); in_valid = 1'b0; #1;
    chk1("frz_pre_valid", obs_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b0;
      #1;
      chk1("frz_valid", obs_valid, 1'b1);
      chk("frz_prod", obs_prod, 64'd10);
      chk1("frz_in_ready", obs_ready, 1'b0);
    end
    @(negedge clk); en = 1'b1; #1;
    chk1("frz_resume_ready", obs_ready, 1'b1);
    chk("frz_resume_prod", obs_prod, 64'd10);
    @(negedge clk); #1;
    chk1("frz_second_valid", obs_valid, 1'b1);
    chk("frz_second_prod", obs_prod, 64'd143);
    @(negedge clk); #1;
    chk1("frz_drain", obs_valid, 1'b0);

    // Asynchronous reset with three ops in flight.
    put(0, 32'd4, 32'd4, 1'b0, 64'd16);
    put(1, 32'd5, 32'd5, 1'b0, 64'd25);
    put(2, 32'd6, 32'd6, 1'b0, 64'd36);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(i);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    chk1("mid_pre_valid", obs_valid, 1'b1);
    chk("mid_pre_prod", obs_prod, 64'd16);
    #1; reset = 1'b0; #1;
    chk1("mid_rst_valid", obs_valid, 1'b0);
    chk("mid_rst_prod", obs_prod, 64'd0);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk1("mid_no_stale", obs_valid, 1'b0);
    end
    put(0, 32'd2, 32'd3, 1'b0, 64'd6);
    stream(1, 3, "post_rst_w32");

    // Narrow, single-stage instance.
    @(negedge clk);
    sel   = 1'b1;
    reset = 1'b0;
    #1;
    chk1("rst2_valid_w8", obs_valid, 1'b0);
    chk1("rst2_ready_w8", obs_ready, 1'b1);
    @(negedge clk); reset = 1'b1;

    put(0, 32'd35, 32'd96, 1'b1, 64'd3360);
    put(1, 32'hFFFF_FFF1, 32'd20, 1'b1, 64'h0000_0000_0000_FED4);
    put(2, 32'hFFFF_FF80, 32'hFFFF_FF80, 1'b1, 64'd16384);
    stream(3, 1, "basic_w8");

    put(0, 32'd1, 32'd40, 1'b0, 64'd40);
    put(1, 32'd36, 32'd42, 1'b0, 64'd1512);
    put(2, 32'd165, 32'd200, 1'b0, 64'd33000);
    put(3, 32'd0, 32'd64, 1'b1, 64'd0);
    put(4, 32'hFFFF_FFEF, 32'hFFFF_FFEF, 1'b1, 64'd289);
    put(5, 32'd7, 32'd7, 1'b1, 64'd49);
    backpressure(6, 1, "bp_w8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_tree_multiplier.md
Name: pipelined_tree_multiplier

Overview:
- Parametrised, pipelined tree multiplier. Successor to the fixed 32-bit tree multiplier.
- Adds configurable operand width and pipeline depth, a per-operation signed/unsigned mode, and a valid/ready handshake with backpressure.
- Sits between the operand-issue logic and the result writeback in the multiplier datapath.
- Sustains one product per cycle when the output is not stalled.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and >= 4. Product is 2*WIDTH bits.
- STAGES, 3, pipeline register stages from operand capture to result. Range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  global pipeline enable. When 0, every stage holds and no handshake completes.
- in_valid  input  1  operand pair a/b/signed_mode is valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  output  1  out_product holds a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_product  output  2*WIDTH  product.

Behaviour:
- Reset (reset=0, asynchronous):
  - All stage valid bits clear; all data registers clear.
  - out_valid=0, out_product=0.
  - in_ready follows its equation, so it reads 1 when en=1.
  - Reset mid-operation discards every in-flight operation; nothing is emitted after release.
- Advance condition:
  - advance = en && (!out_valid || out_ready).
  - in_ready = advance (combinational).
  - Input is accepted when in_valid && in_ready.
- On advance:
  - Every stage shifts forward one position.
  - Stage 0 captures a, b, signed_mode and valid=in_valid.
  - The last stage drives out_valid and out_product.
- When not advancing, all stages hold their values, including bubbles.
- Output stability: out_valid and out_product stay stable while out_valid=1 and out_ready=0.
- Latency: a result appears exactly STAGES advance-cycles after acceptance. With en=1 and out_ready=1 throughout, that is STAGES clock cycles.
- Throughput: one result per cycle. Results leave in acceptance order, with no loss and no duplication.
- Bubbles (in_valid=0 on an advance cycle) propagate as out_valid=0 slots.
- Arithmetic:
  - Each operand is extended to WIDTH+1 bits: sign-extended if signed_mode=1, zero-extended otherwise.
  - The (WIDTH+1)x(WIDTH+1) product is formed; out_product is its low 2*WIDTH bits, which is exact for both modes.
  - signed_mode travels with its operands, so mixed-mode streams are legal back to back.
- Datapath structure:
  - Stage 0: register operands, generate partial products.
  - Middle stages: carry-save tree reduction (3:2 compressors), split as evenly as possible across the remaining stages.
  - Last stage: final carry-propagate add.
  - STAGES=1: the whole datapath is combinational after the stage-0 register.
- Boundary cases:
  - Most-negative signed operands: -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2), no overflow.
  - A zero operand gives 0 regardless of mode.
  - en=0 together with out_ready=1 still holds the output; out_valid may stay 1, and no transfer counts.

Test Plan:
- Basic signed (WIDTH=32, STAGES=3):
  - a=35, b=96, signed_mode=1 accepted at cycle N -> out_valid=1 at cycle N+3 with out_product=3360.
  - Next a=-15, b=20 -> out_product=0xFFFFFFFFFFFFFED4 (-300).
- Mode distinction:
  - a=0xFFFFFFFF, b=2, signed_mode=0 -> 0x00000001FFFFFFFE.
  - Same operands, signed_mode=1 on the next cycle -> 0xFFFFFFFFFFFFFFFE (-2).
- Extremes:
  - a=b=0x80000000, signed_mode=1 -> 0x4000000000000000.
  - a=b=0xFFFFFFFF, signed_mode=0 -> 0xFFFFFFFE00000001.
  - a=3672, b=9648 -> 35427456.
- Backpressure:
  - Stream 6 ops (1*40, 36*42, 165*348, 0*64, -17*-17, 7*7).
  - Hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 while a valid result is stalled.
  - Results stay stable and emerge in order: 40, 1512, 57420, 0, 289, 49. No drops or duplicates.
- Enable freeze:
  - Drop en for 3 cycles with 2 ops in flight -> in_ready=0, pipeline state and outputs unchanged.
  - Results appear after en returns, with total latency of 3 enabled cycles.
- Reset mid-flight:
  - Assert reset=0 asynchronously (between clock edges) with 3 ops in flight -> out_valid=0 and out_product=0 immediately.
  - After release, no stale results appear; a new op 2*3 gives 6 after 3 cycles.
  - Repeat scenarios 1 and 4 with STAGES=1 and WIDTH=8 (a=-128, b=-128 signed -> 16384).
